branch_resolve_unit: RTL
========================

# branch_resolve_unit

Parametrised ID-stage branch resolution block for the pipelined CPU, succeeding the single-mode equality comparator. Evaluates six branch conditions on forwarded operands, stalls while operands are not ready, trains a 2-bit branch history table (BHT) consulted by IF, and emits a registered mispredict/redirect pulse plus saturating performance counters.

## Interface
Parameters:
- DATA_W, 32, operand width
- PC_W, 32, program counter width
- BHT_DEPTH, 16, BHT entries (power of two, ≥2)
- CNT_W, 16, performance counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- if_pc_i  in  PC_W  IF-stage PC for prediction lookup
- pred_taken_o  out  1  BHT prediction for if_pc_i (combinational)
- valid_i  in  1  ID instruction valid
- operation_i  in  4  branch opcode
- pc_i  in  PC_W  ID-stage PC of the branch
- pred_i  in  1  prediction carried from IF with this instruction
- data1_i  in  DATA_W  operand rs
- data2_i  in  DATA_W  operand rt
- operands_ready_i  in  1  hazard unit: forwarded operands valid
- stall_o  out  1  hold IF/ID (combinational)
- taken_o  out  1  registered resolved direction
- flush_o  out  1  registered one-cycle mispredict pulse
- branch_cnt_o  out  CNT_W  resolved branches
- mispredict_cnt_o  out  CNT_W  mispredicted branches

## Operation
- Opcodes: 4'b0111 BEQ, 4'b1000 BNE, 4'b1001 BLT (signed), 4'b1010 BGE (signed), 4'b1011 BLTU, 4'b1100 BGEU; any other value is non-branch.
- is_br = valid_i && opcode in set above.
- stall_o = is_br && !operands_ready_i.
- Accept (resolve) = is_br && operands_ready_i; accept at most one branch per cycle.
- On accept: cond computed from full DATA_W operands; signed compares treat MSB as sign; unsigned compares zero-extend.
- Index = pc_i[$clog2(BHT_DEPTH)+1:2]; same slicing of if_pc_i for lookup.
- BHT entry: 2-bit saturating; taken increments (sat at 3), not-taken decrements (sat at 0); pred_taken_o = entry[1].
- mispredict = accept && (cond != pred_i).
- Counters: branch_cnt increments per accept; mispredict_cnt per mispredict; both saturate at all-ones, never wrap.
- Non-accept cycles: taken_o, flush_o return to 0; BHT and counters unchanged.

## Timing
- Reset (asynchronous, immediate): taken_o=0, flush_o=0, counters=0, every BHT entry=2'b01 (weakly not-taken), so pred_taken_o=0.
- stall_o and pred_taken_o: combinational, same cycle.
- taken_o/flush_o: valid on the cycle after accept edge (latency 1); flush_o high exactly one cycle per mispredict.
- BHT update and counter increment occur at the accept edge.
- Same-cycle lookup and update of one index: pred_taken_o shows the pre-update value (read-before-write).
- Back-to-back accepts: each produces its own registered result; consecutive mispredicts give consecutive flush_o pulses.
- Stall released (operands_ready_i rises): resolve that cycle, result next cycle.
- Reset asserted mid-resolve: pending registered result discarded, all state to reset values.

## Structure
- Shared package branch_pkg: opcode localparams (BR_BEQ…BR_BGEU), function is_branch(op), BHT counter reset constant 2'b01.
- Sub-module branch_cond: combinational (operation_i, data1_i, data2_i) → cond; keeps compare logic separately testable.
- BHT as register array in top; counters in top.

## Test plan
- Reset, BEQ data1=data2=32'h5, pred_i=0, ready=1 → next cycle taken_o=1, flush_o=1, mispredict_cnt=1, BHT[idx] 01→10, pred_taken_o for that PC =1.
- BLT data1=32'hFFFFFFFF, data2=1 → taken; BLTU same operands → not taken; BGE/BGEU complement verified.
- BNE with operands_ready_i=0 for 3 cycles → stall_o=1 for 3 cycles, no counter change; ready rises → resolve, stall_o drops same cycle.
- Four taken resolves at one PC → counter saturates at 3; then one not-taken → 2, prediction still taken.
- Force counters to max-1, two mispredicts → both counters stop at all-ones; opcode 4'b0000 with valid → no stall, no update.
- Assert rst_i between accept edge and next edge → taken_o/flush_o 0 immediately, BHT back to 01.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the ID-stage branch resolution logic: opcode encodings,
// opcode classification and the 2-bit BHT counter behaviour.
package branch_pkg;

  localparam logic [3:0] BR_BEQ  = 4'b0111;
  localparam logic [3:0] BR_BNE  = 4'b1000;
  localparam logic [3:0] BR_BLT  = 4'b1001;
  localparam logic [3:0] BR_BGE  = 4'b1010;
  localparam logic [3:0] BR_BLTU = 4'b1011;
  localparam logic [3:0] BR_BGEU = 4'b1100;

  // Weakly not-taken: the first taken outcome flips the prediction.
  localparam logic [1:0] BHT_RESET = 2'b01;

  typedef enum logic [2:0] {
    CondNone,
    CondEq,
    CondNe,
    CondLt,
    CondGe,
    CondLtu,
    CondGeu
  } cond_kind_e;

  // Map an opcode onto the comparison it requests; non-branches give CondNone.
  function automatic cond_kind_e cond_kind(input logic [3:0] op);
    cond_kind_e kind;
    kind = CondNone;
    case (op)
      BR_BEQ:  kind = CondEq;
      BR_BNE:  kind = CondNe;
      BR_BLT:  kind = CondLt;
      BR_BGE:  kind = CondGe;
      BR_BLTU: kind = CondLtu;
      BR_BGEU: kind = CondGeu;
      default: kind = CondNone;
    endcase
    return kind;
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return cond_kind(op) != CondNone;
  endfunction

  // 2-bit saturating counter step.
  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation on full-width forwarded operands.
module branch_cond
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [3:0]        operation_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic              cond_o
);

  logic       eq;
  logic       lt_s;
  logic       lt_u;
  cond_kind_e kind;

  assign eq   = (data1_i == data2_i);
  assign lt_s = ($signed(data1_i) < $signed(data2_i));
  assign lt_u = (data1_i < data2_i);
  assign kind = cond_kind(operation_i);

  // Select the requested comparison; non-branch opcodes resolve as not taken.
  always_comb begin
    cond_o = 1'b0;
    unique case (kind)
      CondEq:  cond_o = eq;
      CondNe:  cond_o = ~eq;
      CondLt:  cond_o = lt_s;
      CondGe:  cond_o = ~lt_s;
      CondLtu: cond_o = lt_u;
      CondGeu: cond_o = ~lt_u;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: evaluates the branch condition, stalls on unready
// operands, trains the BHT read by IF and reports mispredicts and statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PC_W-1:0]   if_pc_i,
  output logic              pred_taken_o,
  input  logic              valid_i,
  input  logic [3:0]        operation_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              pred_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic              operands_ready_i,
  output logic              stall_o,
  output logic              taken_o,
  output logic              flush_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  mispredict_cnt_o
);

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);

  logic             is_br;
  logic             accept;
  logic             cond;
  logic             mispredict;
  logic [IdxW-1:0]  upd_idx;
  logic [IdxW-1:0]  lkp_idx;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic             taken_q,  taken_d;
  logic             flush_q,  flush_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] misp_cnt_q,   misp_cnt_d;

  // Word-aligned PCs: the two low bits and the bits above the index never select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[PC_W-1:IdxW+2], pc_i[1:0],
                            if_pc_i[PC_W-1:IdxW+2], if_pc_i[1:0]};

  branch_cond #(
    .DATA_W(DATA_W)
  ) u_branch_cond (
    .operation_i(operation_i),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .cond_o     (cond)
  );

  assign is_br      = valid_i && is_branch(operation_i);
  assign stall_o    = is_br && !operands_ready_i;
  assign accept     = is_br && operands_ready_i;
  assign mispredict = accept && (cond != pred_i);

  assign upd_idx = pc_i[IdxW+1:2];
  assign lkp_idx = if_pc_i[IdxW+1:2];

  // Lookup reads the registered entry, so a same-cycle update is not yet visible.
  assign pred_taken_o = bht_q[lkp_idx][1];

  // Next-state for the registered result and the saturating statistics counters.
  always_comb begin
    taken_d      = accept && cond;
    flush_d      = mispredict;
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (accept && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispredict && (misp_cnt_q != {CNT_W{1'b1}})) begin
      misp_cnt_d = misp_cnt_q + CNT_W'(1);
    end
  end

  // Result and counter registers; reset discards any pending result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      taken_q      <= 1'b0;
      flush_q      <= 1'b0;
      branch_cnt_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      taken_q      <= taken_d;
      flush_q      <= flush_d;
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  // BHT training: only the resolved branch's entry moves, and only on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= BHT_RESET;
      end
    end else if (accept) begin
      bht_q[upd_idx] <= bht_next(bht_q[upd_idx], cond);
    end
  end

  assign taken_o          = taken_q;
  assign flush_o          = flush_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = misp_cnt_q;

endmodule
